// File: rtl/fixed_vec3_normalize_seq_if.sv
// Start/done handshake and vector bundle for the sequential normalizer.
interface fixed_vec3_normalize_seq_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] ny;
    logic [WIDTH-1:0] nz;
    logic [WIDTH-1:0] mag;
    logic             err;

    modport master (
        output start, x, y, z,
        input  busy, done, nx, ny, nz, mag, err
    );

    modport slave (
        input  start, x, y, z,
        output busy, done, nx, ny, nz, mag, err
    );
endinterface

// File: rtl/fixed_vec3_normalize_seq.sv
// Sequential Q-format 3-vector normalize: one squarer/accumulator,
// bit-serial restoring square root and bit-serial restoring divider.
module fixed_vec3_normalize_seq #(
    parameter int WIDTH = 12,
    parameter int FRAC  = 4
) (
    input logic clk,
    input logic rst_n,
    fixed_vec3_normalize_seq_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int DW = WIDTH + FRAC;
    localparam int SW = 2 * WIDTH + 2;
    localparam int CW = $clog2(DW + 1);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [2:0] {
        IDLE, SQ, SQRT, DIV, DONE
    } state_t;

    state_t state_q, state_d;
    logic [W-1:0]  xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [W+1:0]  srem_q, srem_d;
    logic [W:0]    root_q, root_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [W-1:0]  drem_q, drem_d;
    logic [W-1:0]  qt_q, qt_d;
    logic [W-1:0]  qx_q, qx_d, qy_q, qy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [W-1:0]  nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
    logic [W-1:0]  mag_q, mag_d;
    logic          err_q, err_d;

    logic [W-1:0]          cur, nxt, cur_abs, nxt_abs;
    logic signed [2*W-1:0] prod;
    logic [W+3:0]          srem_sh, trial;
    logic                  s_ge, d_ge;
    logic [W:0]            root_nx, drem_sh;
    logic [W-1:0]          m, qt_nx, q_sgn;

    // sel picks the component for both the squaring and the dividing phase
    assign cur = (sel_q == 2'd0) ? xr_q : (sel_q == 2'd1) ? yr_q : zr_q;
    assign nxt = (sel_q == 2'd0) ? yr_q : zr_q;
    assign cur_abs = cur[W-1] ? (~cur + ONE) : cur;
    assign nxt_abs = nxt[W-1] ? (~nxt + ONE) : nxt;
    assign prod = $signed(cur) * $signed(cur);

    assign srem_sh = {srem_q, acc_q[SW-1:SW-2]};
    assign trial   = {1'b0, root_q, 2'b01};
    assign s_ge    = srem_sh >= trial;
    assign root_nx = {root_q[W-1:0], s_ge};

    assign m       = root_q[W-1:0];
    assign drem_sh = {drem_q, dvd_q[DW-1]};
    assign d_ge    = drem_sh >= {1'b0, m};
    assign qt_nx   = {qt_q[W-2:0], d_ge};
    assign q_sgn   = cur[W-1] ? (~qt_nx + ONE) : qt_nx;

    always_comb begin
        state_d = state_q;
        xr_d = xr_q; yr_d = yr_q; zr_d = zr_q;
        acc_d = acc_q; srem_d = srem_q; root_d = root_q;
        dvd_d = dvd_q; drem_d = drem_q; qt_d = qt_q;
        qx_d = qx_q; qy_d = qy_q;
        cnt_d = cnt_q; sel_d = sel_q;
        nx_d = nx_q; ny_d = ny_q; nz_d = nz_q;
        mag_d = mag_q; err_d = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xr_d = bus.x; yr_d = bus.y; zr_d = bus.z;
                    acc_d = '0; srem_d = '0; root_d = '0;
                    sel_d = 2'd0; cnt_d = '0;
                    state_d = SQ;
                end
            end
            SQ: begin
                acc_d = acc_q + {2'b00, prod};
                sel_d = sel_q + 2'd1;
                if (sel_q == 2'd2) begin
                    sel_d = 2'd0;
                    state_d = SQRT;
                end
            end
            SQRT: begin
                acc_d  = acc_q << 2;
                srem_d = s_ge ? (srem_sh[W+1:0] - trial[W+1:0])
                              : srem_sh[W+1:0];
                root_d = root_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W)) begin
                    cnt_d = '0;
                    if (root_nx == '0) begin
                        err_d = 1'b1;
                        nx_d = '0; ny_d = '0; nz_d = '0;
                        mag_d = '0;
                        state_d = DONE;
                    end else begin
                        dvd_d = {cur_abs, {FRAC{1'b0}}};
                        drem_d = '0; qt_d = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                dvd_d  = dvd_q << 1;
                drem_d = d_ge ? (drem_sh[W-1:0] - m) : drem_sh[W-1:0];
                qt_d   = qt_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    cnt_d = '0;
                    drem_d = '0; qt_d = '0;
                    dvd_d = {nxt_abs, {FRAC{1'b0}}};
                    sel_d = sel_q + 2'd1;
                    if (sel_q == 2'd0) qx_d = q_sgn;
                    if (sel_q == 2'd1) qy_d = q_sgn;
                    if (sel_q == 2'd2) begin
                        nx_d = qx_q; ny_d = qy_q; nz_d = q_sgn;
                        mag_d = m;
                        err_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xr_q <= '0; yr_q <= '0; zr_q <= '0;
            acc_q <= '0; srem_q <= '0; root_q <= '0;
            dvd_q <= '0; drem_q <= '0; qt_q <= '0;
            qx_q <= '0; qy_q <= '0;
            cnt_q <= '0; sel_q <= '0;
            nx_q <= '0; ny_q <= '0; nz_q <= '0;
            mag_q <= '0; err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q <= xr_d; yr_q <= yr_d; zr_q <= zr_d;
            acc_q <= acc_d; srem_q <= srem_d; root_q <= root_d;
            dvd_q <= dvd_d; drem_q <= drem_d; qt_q <= qt_d;
            qx_q <= qx_d; qy_q <= qy_d;
            cnt_q <= cnt_d; sel_q <= sel_d;
            nx_q <= nx_d; ny_q <= ny_d; nz_q <= nz_d;
            mag_q <= mag_d; err_q <= err_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.nx   = nx_q;
    assign bus.ny   = ny_q;
    assign bus.nz   = nz_q;
    assign bus.mag  = mag_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_fixed_vec3_normalize_seq.sv
// Scoreboard bench for fixed_vec3_normalize_seq: directed vectors,
// held-start, mid-operation reset and random vectors vs a golden model.
module tb_fixed_vec3_normalize_seq;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fixed_vec3_normalize_seq_if #(.WIDTH(W)) bus ();

    fixed_vec3_normalize_seq #(.WIDTH(W), .FRAC(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string        name;
        int           t0;
        int           lat;
        logic [W-1:0] nx, ny, nz, mag;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run = 0;
    int last_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input string n, input int lat,
                                input int nx, input int ny, input int nz,
                                input int mag, input bit err);
        exp_t e;
        e.name = n; e.t0 = 0; e.lat = lat;
        e.nx = W'(nx); e.ny = W'(ny); e.nz = W'(nz);
        e.mag = W'(mag); e.err = err;
        return e;
    endfunction

    function automatic int qdiv(input int c, input int m);
        int a;
        a = (c < 0) ? -c : c;
        a = (a * 16) / m;
        return (c < 0) ? -a : a;
    endfunction

    function automatic exp_t model(input string n, input int x,
                                   input int y, input int z);
        longint s;
        longint r;
        s = longint'(x) * x + longint'(y) * y + longint'(z) * z;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        if (r == 0) return mk(n, 17, 0, 0, 0, 0, 1'b1);
        return mk(n, 65, qdiv(x, int'(r)), qdiv(y, int'(r)),
                  qdiv(z, int'(r)), int'(r), 1'b0);
    endfunction

    function automatic bit in_range(input logic [W-1:0] v);
        int s;
        s = int'($signed(v));
        return (s >= -16) && (s <= 16);
    endfunction

    // Monitor: every done pulse pops one expectation and checks it.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (rst_n && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_lat"}, cyc - e.t0, e.lat);
                check({e.name, "_mag"}, bus.mag, e.mag);
                check({e.name, "_nx"}, bus.nx, e.nx);
                check({e.name, "_ny"}, bus.ny, e.ny);
                check({e.name, "_nz"}, bus.nz, e.nz);
                check({e.name, "_err"}, bus.err, e.err);
                check({e.name, "_range"},
                      in_range(bus.nx) && in_range(bus.ny)
                      && in_range(bus.nz), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(bus.busy === 1'b0 && bus.done === 1'b0)) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                check("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                check("drain_timeout", sbq.size(), 32'd0);
                sbq.delete();
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input exp_t e);
        wait_idle();
        bus.x = x; bus.y = y; bus.z = z;
        bus.start = 1'b1;
        e.t0 = cyc;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 32'd0);
        check({tag, "_done"}, bus.done, 32'd0);
        check({tag, "_nx"}, bus.nx, 32'd0);
        check({tag, "_ny"}, bus.ny, 32'd0);
        check({tag, "_nz"}, bus.nz, 32'd0);
        check({tag, "_mag"}, bus.mag, 32'd0);
        check({tag, "_err"}, bus.err, 32'd0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx, ry, rz;
        int accepts;
        bus.start = 1'b0;
        bus.x = '0; bus.y = '0; bus.z = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(12'd48, 12'd64, 12'd0, mk("v345", 65, 9, 12, 0, 80, 0));
        drain();
        check("v345_busy_len", last_run, 32'd65);
        repeat (5) @(negedge clk);
        check("v345_hold_nx", bus.nx, 32'd9);
        check("v345_hold_mag", bus.mag, 32'd80);

        issue(12'd0, 12'd0, 12'd0, mk("zero", 17, 0, 0, 0, 0, 1));
        issue(12'd16, 12'd16, 12'd16, mk("v16", 65, 9, 9, 9, 27, 0));
        issue(12'h800, 12'd0, 12'd0, mk("neg2048", 65, -16, 0, 0, 2048, 0));
        issue(12'd1, 12'hFFF, 12'd1, mk("tiny", 65, 16, -16, 16, 1, 0));
        drain();

        // Start held high, inputs changing every cycle.
        accepts = 0;
        for (int i = 0; i < 140; i++) begin
            rx = W'($urandom); ry = W'($urandom); rz = W'($urandom);
            bus.x = rx; bus.y = ry; bus.z = rz;
            bus.start = 1'b1;
            if (bus.busy === 1'b0 && bus.done === 1'b0) begin
                exp_t e;
                e = model("held", int'($signed(rx)), int'($signed(ry)),
                          int'($signed(rz)));
                e.t0 = cyc;
                sbq.push_back(e);
                accepts++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("held_accepts", accepts, 32'd3);
        drain();

        // Reset at cycle 30 of an operation.
        issue(12'd48, 12'd64, 12'd0, mk("aborted", 65, 9, 12, 0, 80, 0));
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        issue(12'd16, 12'd16, 12'd16, mk("post_rst", 65, 9, 9, 9, 27, 0));
        drain();

        for (int i = 0; i < 1000; i++) begin
            rx = W'($urandom); ry = W'($urandom); rz = W'($urandom);
            issue(rx, ry, rz, model("rand", int'($signed(rx)),
                  int'($signed(ry)), int'($signed(rz))));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
